// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU and its micro-sequencer.
// ALU command codes, sequencer opcodes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_CMP    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_CMPI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT_WAIT,
    S_HALT
  } state_t;

endpackage

// File: rtl/alu_sequencer_pc.sv
// Program counter: clear, load, increment with wrap.
// Ports: clk, rst, clr, load, inc, din -> pc.
module program_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] din,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= '0;
    else if (clr)  pc <= '0;
    else if (load) pc <= din;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer driving an external 4-bit ALU from program memory.
// Ports: start/halted control, imem fetch handshake, ALU drive/return, out port.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [7:0]        imem_data,
  output logic [2:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  state_t            state, nxt;
  logic [7:0]        ir;
  logic [DATA_W-1:0] acc;
  logic              flag_c, flag_z;
  logic [ADDR_W-1:0] pc, pc_din;
  logic              pc_clr, pc_ld, pc_inc;
  logic              ir_ld, acc_ld, flg_ld, out_ld;
  logic [3:0]        op, imm;

  assign op  = ir[7:4];
  assign imm = ir[3:0];

  program_counter #(.W(ADDR_W)) u_pc (
    .clk  (clk),
    .rst  (reset),
    .clr  (pc_clr),
    .load (pc_ld),
    .inc  (pc_inc),
    .din  (pc_din),
    .pc   (pc)
  );

  // Handshake outputs decode straight from state so reset
  // drops them without waiting for a clock edge.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign out_valid = (state == S_OUT_WAIT);
  assign halted    = (state == S_IDLE) || (state == S_HALT);
  assign alu_a     = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    pc_clr  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    acc_ld  = 1'b0;
    flg_ld  = 1'b0;
    out_ld  = 1'b0;
    alu_cmd = ALU_PASS_A;
    alu_b   = '0;
    pc_din  = ADDR_W'(imm);
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_clr = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_ld = 1'b1;
          nxt   = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_b  = DATA_W'(imm);
        pc_inc = 1'b1;
        nxt    = S_FETCH;
        unique case (1'b1)
          (op == OP_LDI): begin
            alu_cmd = ALU_PASS_B;
            acc_ld  = 1'b1;
          end
          (op == OP_ADDI): begin
            alu_cmd = ALU_ADD;
            acc_ld  = 1'b1;
            flg_ld  = 1'b1;
          end
          (op == OP_CMPI): begin
            alu_cmd = ALU_CMP;
            flg_ld  = 1'b1;
          end
          (op == OP_NANDI): begin
            alu_cmd = ALU_NAND;
            acc_ld  = 1'b1;
          end
          (op == OP_OUT): begin
            out_ld = 1'b1;
            nxt    = S_OUT_WAIT;
          end
          (op == OP_JMP): begin
            pc_inc = 1'b0;
            pc_ld  = 1'b1;
          end
          (op == OP_JC): begin
            pc_inc = !flag_c;
            pc_ld  = flag_c;
          end
          (op == OP_JZ): begin
            pc_inc = !flag_z;
            pc_ld  = flag_z;
          end
          (op == OP_HALT): nxt = S_HALT;
          default: ;
        endcase
      end
      S_OUT_WAIT: begin
        if (out_ready) nxt = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      acc      <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      out_data <= '0;
    end else begin
      if (ir_ld)  ir <= imem_data;
      if (acc_ld) acc <= alu_result;
      if (flg_ld) begin
        flag_c <= alu_carry;
        flag_z <= alu_zero;
      end
      if (out_ld) out_data <= acc;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer against an instruction-level model.
// Provides the ALU, program memory and output consumer around the DUT.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       imem_req, imem_ready;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [2:0] alu_cmd;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_carry, alu_zero;
  logic [3:0] out_data;
  logic       out_valid, out_ready, halted;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .alu_cmd    (alu_cmd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted)
  );

  // Lab ALU: compare is A + ~B + 1, so carry means A >= B.
  logic [4:0] alu_s;
  always_comb begin
    alu_s = '0;
    case (alu_cmd)
      3'b000: alu_s = {1'b0, alu_a};
      3'b001: alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'b010: alu_s = {1'b0, alu_b};
      3'b011: alu_s = {1'b0, alu_a} + {1'b0, alu_b};
      3'b100: alu_s = {1'b0, ~(alu_a & alu_b)};
      default: alu_s = '0;
    endcase
  end
  assign alu_result = alu_s[3:0];
  assign alu_carry  = alu_s[4];
  assign alu_zero   = (alu_s[3:0] == 4'd0);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  logic [7:0] prog [16];
  int exp_fetch [$];
  int exp_out [$];
  int fcnt, ocnt, kmax;
  int lat_lo, lat_hi, olat_lo, olat_hi;
  int wcnt, wlat, ocw, olat;
  bit mon_en = 0, noise_en = 0, start_req = 0;
  logic p_req = 0, p_rdy = 0, p_ov = 0, p_ordy = 0;
  logic [3:0] p_addr = 0, p_od = 0;

  // Memory, consumer and start-noise responder; also checks that
  // pending handshakes keep their request and payload stable.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (p_req && !p_rdy) begin
        check("req_hold", imem_req, 1);
        check("addr_hold", imem_addr, p_addr);
      end
      if (p_ov && !p_ordy) begin
        check("valid_hold", out_valid, 1);
        check("data_hold", out_data, p_od);
        check("pc_frozen", imem_addr, p_addr);
      end
    end
    if (reset || !imem_req) begin
      imem_ready = 1'b0;
      wcnt = 0;
    end else if (wcnt >= wlat && fcnt < kmax) begin
      imem_ready = 1'b1;
      imem_data = prog[imem_addr];
      fcnt++;
      if (mon_en) begin
        check("fetch_queue", exp_fetch.size() > 0, 1);
        if (exp_fetch.size() > 0)
          check("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
      wcnt = 0;
      wlat = $urandom_range(lat_hi, lat_lo);
    end else begin
      imem_ready = 1'b0;
      imem_data = 8'($urandom);
      wcnt++;
    end
    if (reset || !out_valid) begin
      out_ready = 1'b0;
      ocw = 0;
    end else if (ocw >= olat) begin
      out_ready = 1'b1;
      ocnt++;
      if (mon_en) begin
        check("out_queue", exp_out.size() > 0, 1);
        if (exp_out.size() > 0)
          check("out_data", out_data, exp_out.pop_front());
      end
      ocw = 0;
      olat = $urandom_range(olat_hi, olat_lo);
    end else begin
      out_ready = 1'b0;
      ocw++;
    end
    start = start_req ||
            (noise_en && !reset && !halted && $urandom_range(7, 0) == 0);
    p_req  = reset ? 1'b0 : imem_req;
    p_rdy  = imem_ready;
    p_addr = imem_addr;
    p_ov   = reset ? 1'b0 : out_valid;
    p_ordy = out_ready;
    p_od   = out_data;
  end

  // Instruction-level model: runs up to k instructions from pc 0
  // with cleared acc/flags and records fetch addresses and outputs.
  task automatic model(input int k, output bit hlt, output logic [3:0] pcf);
    logic [3:0] pc, acc, op, imm;
    bit c, z;
    int s;
    pc = 0; acc = 0; c = 0; z = 0; hlt = 0;
    exp_fetch.delete();
    exp_out.delete();
    for (int i = 0; i < k && !hlt; i++) begin
      exp_fetch.push_back(int'(pc));
      op  = prog[pc][7:4];
      imm = prog[pc][3:0];
      pc  = pc + 4'd1;
      case (op)
        4'h1: acc = imm;
        4'h2: begin
          s   = int'(acc) + int'(imm);
          acc = s[3:0];
          c   = (s > 15);
          z   = (s[3:0] == 0);
        end
        4'h3: begin
          c = (acc >= imm);
          z = (acc == imm);
        end
        4'h4: acc = ~(acc & imm);
        4'h5: exp_out.push_back(int'(acc));
        4'h6: pc = imm;
        4'h7: if (c) pc = imm;
        4'h8: if (z) pc = imm;
        4'h9: hlt = 1;
        default: ;
      endcase
    end
    pcf = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1 start_req = 1'b1;
    @(negedge clk);
    #1 start_req = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic run_prog(input int k, input int lo, input int hi,
                          input int olo, input int ohi,
                          input bit rst_first, input bit noise);
    bit eh;
    logic [3:0] ep;
    int nf, no, cyc;
    if (rst_first) do_reset();
    lat_lo = lo; lat_hi = hi; olat_lo = olo; olat_hi = ohi;
    wlat = $urandom_range(hi, lo);
    olat = $urandom_range(ohi, olo);
    kmax = k; fcnt = 0; ocnt = 0;
    model(k, eh, ep);
    nf = exp_fetch.size();
    no = exp_out.size();
    mon_en = 1;
    pulse_start();
    noise_en = noise;
    cyc = 0;
    do begin
      @(negedge clk);
      #1 cyc++;
    end while (!halted && fcnt < kmax && cyc < 4000);
    if (!halted) begin
      @(negedge clk);
      #1;
      while (!imem_req && !halted && cyc < 4000) begin
        @(negedge clk);
        #1 cyc++;
      end
    end
    noise_en = 0;
    check("timeout", cyc < 4000, 1);
    check("fetch_count", fcnt, nf);
    check("out_count", ocnt, no);
    check("halted", halted, eh);
    if (eh) check("halt_pc", imem_addr, ep);
    mon_en = 0;
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; imem_ready = 1'b0;
    imem_data = 8'h00; out_ready = 1'b0;
    kmax = 0; lat_lo = 0; lat_hi = 0; olat_lo = 0; olat_hi = 0;
    clear_prog();
    #12;
    check("rst_req", imem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out", out_data, 0);
    check("rst_halted", halted, 1);
    check("rst_cmd", alu_cmd, 0);
    check("rst_b", alu_b, 0);
    check("rst_addr", imem_addr, 0);

    // LDI 3, ADDI 4, OUT, HALT: zero wait, slow fetch, slow consumer.
    clear_prog();
    prog[0] = 8'h13; prog[1] = 8'h24; prog[2] = 8'h50; prog[3] = 8'h90;
    run_prog(40, 0, 0, 0, 0, 1, 0);
    run_prog(40, 3, 3, 0, 0, 1, 0);
    run_prog(40, 0, 0, 4, 4, 1, 0);

    // Carry-taken jump over unused slots to OUT.
    clear_prog();
    prog[0] = 8'h19; prog[1] = 8'h27; prog[2] = 8'h75;
    prog[3] = 8'h50; prog[4] = 8'h50;
    prog[5] = 8'h50; prog[6] = 8'h90;
    run_prog(40, 0, 0, 0, 0, 1, 0);

    // Equal compare takes JZ past the OUT.
    clear_prog();
    prog[0] = 8'h15; prog[1] = 8'h35; prog[2] = 8'h84;
    prog[3] = 8'h50; prog[4] = 8'h90;
    run_prog(40, 0, 0, 0, 0, 1, 0);

    // Reset while instruction 1 fetch is pending; rerun must see acc=0.
    clear_prog();
    prog[0] = 8'h23; prog[1] = 8'h24; prog[2] = 8'h50; prog[3] = 8'h90;
    do_reset();
    lat_lo = 3; lat_hi = 3; wlat = 3; kmax = 99;
    pulse_start();
    cyc = 0;
    while (!(imem_req && imem_addr == 4'd1) && cyc < 100) begin
      @(negedge clk);
      #1 cyc++;
    end
    check("mid_fetch_reached", cyc < 100, 1);
    check("mid_acc", alu_a, 3);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_valid", out_valid, 0);
    check("arst_halted", halted, 1);
    check("arst_addr", imem_addr, 0);
    check("arst_out", out_data, 0);
    check("arst_cmd", alu_cmd, 0);
    check("arst_b", alu_b, 0);
    check("arst_acc", alu_a, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    run_prog(40, 0, 0, 0, 0, 0, 0);

    // Random programs with random latencies and spurious start pulses.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      run_prog(40, 0, 3, 0, 3, 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Micro-sequencer for the lab's 4-bit ALU (commands: pass A, compare A−B, pass B, add, NAND; outputs result/carry/zero).
- Fetches 8-bit instructions from an external program memory and drives the ALU with accumulator and immediate operands.
- Latches the ALU result into the accumulator and its flags into a flags register; executes conditional jumps and an output port.
- Sits between program ROM, the combinational ALU (instantiated alongside, not inside) and the board output LEDs/display.

Parameters:
- ADDR_W, 4, program counter / memory address width; jump immediates are zero-extended to ADDR_W.
- DATA_W, 4, accumulator and ALU operand width; fixed at 4 to match the ALU.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse; starts or restarts the program from address 0.
- imem_req  out  1  fetch request; held until imem_ready.
- imem_addr  out  ADDR_W  fetch address (= pc); stable while imem_req is high.
- imem_ready  in  1  imem_data valid this cycle.
- imem_data  in  8  instruction: [7:4] opcode, [3:0] immediate.
- alu_cmd  out  3  ALU command.
- alu_a  out  4  ALU operand A (always acc).
- alu_b  out  4  ALU operand B (immediate in EXEC, else 0).
- alu_result  in  4  ALU result.
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero/exit flag.
- out_data  out  4  output register.
- out_valid  out  1  out_data offered; held until out_ready.
- out_ready  in  1  consumer accepts.
- halted  out  1  high in IDLE and HALT.

Behaviour:
- Reset: pc=0, acc=0, flag_c=0, flag_z=0, ir=0, state=IDLE. Outputs: imem_req=0, out_valid=0, out_data=0, halted=1, alu_cmd=000, alu_b=0.
- FSM states: IDLE, FETCH, EXEC, OUT_WAIT, HALT.
- IDLE/HALT:
  - start → pc=0, go to FETCH.
  - acc and flags are cleared only by reset.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: ir<=imem_data, go to EXEC. Zero-wait memory gives 1 cycle of FETCH.
- EXEC (one cycle):
  - ALU driven combinationally and sampled the same edge.
  - pc<=pc+1 (mod 2^ADDR_W) unless a jump is taken.
  - Next state is FETCH unless stated otherwise.
- Opcodes:
  - 0x0 NOP: no state change.
  - 0x1 LDI: cmd 010 → acc<=result; flags unchanged.
  - 0x2 ADDI: cmd 011 → acc<=result, flag_c<=carry, flag_z<=zero.
  - 0x3 CMPI: cmd 001 → flags<=carry, zero; acc unchanged.
  - 0x4 NANDI: cmd 100 → acc<=result; flags unchanged.
  - 0x5 OUT: out_data<=acc, out_valid<=1, go to OUT_WAIT.
  - 0x6 JMP: pc<=imm.
  - 0x7 JC: pc<=imm if flag_c, else pc+1.
  - 0x8 JZ: pc<=imm if flag_z, else pc+1.
  - 0x9 HALT: go to HALT; pc holds the address after HALT.
  - 0xA–0xF: treated as NOP.
- Outside EXEC: alu_cmd=000, alu_b=0.
- OUT_WAIT:
  - out_valid stays high and out_data stays stable.
  - On out_ready: out_valid<=0 on the next edge, go to FETCH.
  - out_ready already high at entry → exactly 1 cycle in OUT_WAIT.
- start while running (FETCH/EXEC/OUT_WAIT) is ignored.
- Reset mid-fetch or mid-output: all state returns to reset values at once; imem_req and out_valid drop asynchronously.
- pc wrap: 0xF+1 → 0x0 with no flag effect.

Decomposition:
- Shared package alu_pkg:
  - ALU command constants (ALU_PASS_A=000, ALU_CMP=001, ALU_PASS_B=010, ALU_ADD=011, ALU_NAND=100), so the ALU and sequencer share one definition.
  - Opcode constants 0x0–0x9.
  - FSM state encoding.
- One sub-module, program_counter: load, increment with wrap, clear, async reset.

Test Plan:
- Program [LDI 3, ADDI 4, OUT, HALT] with zero-wait memory → out_data=7 with out_valid, then halted=1; flag_c=0, flag_z=0.
- [LDI 9, ADDI 7, JC 5, …, @5 OUT, HALT] → carry set, jump taken, out_data=0, flag_z=1.
- [LDI 5, CMPI 5, JZ 4, OUT, @4 HALT] → flag_z=1, no out_valid pulse, halted at pc=5.
- imem_ready delayed 3 cycles per fetch → imem_req/imem_addr stable throughout; same results as zero-wait run.
- OUT with out_ready low for 4 cycles → out_valid held 4+ cycles, out_data stable, pc frozen.
- Reset asserted mid-FETCH of instruction 2 → all outputs at reset values immediately; start then reruns the program from pc=0 with acc=0.
